// File: rtl/uc_loop.sv
// Control decoder for the single-cycle microcontroller with a hardware loop-counter stack.
// Zero-latency combinational decode; stack and sticky err update on the edge ending SETLC/LOOP; no backpressure.
module uc_loop #(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic [2:0] depth,
  output logic       err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DMAX = 3'(DEPTH);

  typedef enum logic [2:0] {
    CL_ALU   = 3'b000,
    CL_LI    = 3'b001,
    CL_J     = 3'b010,
    CL_JZ    = 3'b011,
    CL_JNZ   = 3'b100,
    CL_NOP   = 3'b101,
    CL_SETLC = 3'b110,
    CL_LOOP  = 3'b111
  } cls_t;

  cls_t          cls;
  logic [2:0]    f;
  logic [2:0]    sp;
  logic [CW-1:0] stk [DEPTH];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;
  logic [CW-1:0] top;
  logic          full;
  logic          empty;
  logic          top_gt1;

  assign cls      = cls_t'(Opcode[5:3]);
  assign f        = Opcode[2:0];
  assign full     = (sp == DMAX);
  assign empty    = (sp == 3'd0);
  assign top_idx  = AW'(sp - 3'd1);
  assign push_idx = AW'(sp);
  assign top      = stk[top_idx];
  assign top_gt1  = (top > CW'(1));
  assign depth    = sp;

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    Op    = f;
    if (reset) begin
      Op = 3'd0;
    end else begin
      case (cls)
        CL_ALU: begin
          we3 = 1'b1;
          wez = 1'b1;
        end
        CL_LI: begin
          s_inm = 1'b1;
          we3   = 1'b1;
        end
        CL_J:    s_inc = 1'b0;
        CL_JZ:   s_inc = ~z;
        CL_JNZ:  s_inc = z;
        // An empty stack falls through; a count of 1 is the final pass.
        CL_LOOP: s_inc = ~(~empty & top_gt1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= 3'd0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      case (cls)
        CL_SETLC: begin
          if (full) begin
            err <= 1'b1;
          end else begin
            stk[push_idx] <= CW'(f) + CW'(1);
            sp            <= sp + 3'd1;
          end
        end
        CL_LOOP: begin
          if (empty) begin
            err <= 1'b1;
          end else if (top_gt1) begin
            stk[top_idx] <= top - CW'(1);
          end else begin
            sp <= sp - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_loop.sv
// Directed and randomized bench for uc_loop against a queue-based loop-stack model.
module tb_uc_loop;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       z;
  logic       s_inc, s_inm, we3, wez, err;
  logic [2:0] Op, depth;

  uc_loop #(.DEPTH(DEPTH), .CW(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .Op(Op), .depth(depth), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: pending loop counts (back = innermost) and sticky error.
  int q[$];
  bit merr = 1'b0;

  logic       dut_sinc;
  logic [5:0] prog [16];
  int         tgt [16];
  int         execs [16];
  int         peak;
  logic [7:0] loopseq;
  int         nloops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one instruction at posedge+1, check control mid-cycle, then update the model after the edge.
  task automatic issue(input logic [5:0] op, input logic zz);
    logic [2:0] c, fv;
    logic e_sinc, e_sinm, e_we3, e_wez;
    c = op[5:3];
    fv = op[2:0];
    Opcode = op;
    z = zz;
    e_sinc = 1'b1; e_sinm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0;
    case (c)
      3'b000: begin e_we3 = 1'b1; e_wez = 1'b1; end
      3'b001: begin e_sinm = 1'b1; e_we3 = 1'b1; end
      3'b010: e_sinc = 1'b0;
      3'b011: e_sinc = !zz;
      3'b100: e_sinc = zz;
      3'b111: if (q.size() > 0 && q[q.size()-1] > 1) e_sinc = 1'b0;
      default: ;
    endcase
    @(negedge clk);
    dut_sinc = s_inc;
    check("s_inc", 32'(s_inc), 32'(e_sinc));
    check("s_inm", 32'(s_inm), 32'(e_sinm));
    check("we3", 32'(we3), 32'(e_we3));
    check("wez", 32'(wez), 32'(e_wez));
    check("Op", 32'(Op), 32'(fv));
    check("depth", 32'(depth), 32'(q.size()));
    check("err", 32'(err), 32'(merr));
    @(posedge clk);
    #1;
    if (c == 3'b110) begin
      if (q.size() == DEPTH) merr = 1'b1;
      else q.push_back(int'(fv) + 1);
    end else if (c == 3'b111) begin
      if (q.size() == 0) merr = 1'b1;
      else if (q[q.size()-1] > 1) q[q.size()-1] = q[q.size()-1] - 1;
      else void'(q.pop_back());
    end
  endtask

  // Follow the DUT's branch decisions through a small program; bounded by a step budget.
  task automatic run_prog(input int plen);
    int pc, steps;
    pc = 0; steps = 0; nloops = 0; loopseq = '0; peak = q.size();
    for (int i = 0; i < 16; i++) execs[i] = 0;
    while (pc < plen && steps < 200) begin
      execs[pc]++;
      issue(prog[pc], 1'b0);
      if (prog[pc][5:3] == 3'b111 && nloops < 8) begin
        loopseq[nloops] = dut_sinc;
        nloops++;
      end
      pc = dut_sinc ? pc + 1 : tgt[pc];
      steps++;
      if (int'(depth) > peak) peak = int'(depth);
    end
    check("prog_terminates", 32'(steps < 200), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    Opcode = 6'b000_101;
    z = 1'b0;
    #12;
    check("rst_s_inc", 32'(s_inc), 32'd1);
    check("rst_s_inm", 32'(s_inm), 32'd0);
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_wez", 32'(wez), 32'd0);
    check("rst_Op", 32'(Op), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ALU decode and conditional jumps
    issue(6'b000_101, 1'b0);
    issue(6'b001_011, 1'b0);
    issue(6'b010_000, 1'b1);
    issue(6'b011_000, 1'b1);
    issue(6'b011_000, 1'b0);
    issue(6'b100_000, 1'b1);
    issue(6'b100_000, 1'b0);
    issue(6'b101_110, 1'b1);

    // Counted loop: SETLC f=2, two-instruction body, LOOP
    prog[0] = 6'b110_010; tgt[0] = 0;
    prog[1] = 6'b000_001; tgt[1] = 0;
    prog[2] = 6'b001_100; tgt[2] = 0;
    prog[3] = 6'b111_000; tgt[3] = 1;
    run_prog(4);
    check("loop_body_execs", 32'(execs[1]), 32'd3);
    check("loop_sinc_seq", 32'(loopseq[2:0]), 32'b100);
    check("loop_nloops", 32'(nloops), 32'd3);
    check("loop_peak", 32'(peak), 32'd1);
    check("loop_end_depth", 32'(depth), 32'd0);

    // Nested: outer f=1 around inner f=2
    prog[0] = 6'b110_001; tgt[0] = 0;
    prog[1] = 6'b000_010; tgt[1] = 0;
    prog[2] = 6'b110_010; tgt[2] = 0;
    prog[3] = 6'b101_000; tgt[3] = 0;
    prog[4] = 6'b111_000; tgt[4] = 3;
    prog[5] = 6'b111_000; tgt[5] = 1;
    run_prog(6);
    check("nest_inner_execs", 32'(execs[3]), 32'd6);
    check("nest_outer_execs", 32'(execs[1]), 32'd2);
    check("nest_peak", 32'(peak), 32'd2);
    check("nest_end_depth", 32'(depth), 32'd0);
    check("nest_end_err", 32'(err), 32'd0);

    // Overflow, pop of a top=1 entry, then underflow
    for (int i = 0; i < 5; i++) issue(6'b110_000, 1'b0);
    check("ovf_depth", 32'(depth), 32'd4);
    check("ovf_err", 32'(err), 32'd1);
    issue(6'b111_000, 1'b0);
    check("pop_depth", 32'(depth), 32'd3);
    for (int i = 0; i < 3; i++) issue(6'b111_000, 1'b0);
    issue(6'b111_000, 1'b0);
    check("udf_s_inc", 32'(dut_sinc), 32'd1);
    check("udf_depth", 32'(depth), 32'd0);
    check("udf_err", 32'(err), 32'd1);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      issue(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a nested loop
    issue(6'b110_011, 1'b0);
    issue(6'b110_001, 1'b0);
    if (q.size() < DEPTH) issue(6'b000_000, 1'b0);
    Opcode = 6'b000_111;
    #2;
    reset = 1'b1;
    q.delete();
    merr = 1'b0;
    #1;
    check("mid_rst_depth", 32'(depth), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_s_inc", 32'(s_inc), 32'd1);
    check("mid_rst_we3", 32'(we3), 32'd0);
    check("mid_rst_wez", 32'(wez), 32'd0);
    check("mid_rst_Op", 32'(Op), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(6'b111_000, 1'b0);
    issue(6'b110_000, 1'b0);
    issue(6'b111_000, 1'b0);
    check("post_rst_depth", 32'(depth), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_loop.md
# uc_loop

Sequential control unit for the single-cycle microcontroller datapath. It decodes the 6-bit `Opcode` and the registered zero flag `z` into the datapath control signals `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It also owns a 4-deep hardware loop-counter stack, so counted loops (including nested ones) run without spending registers or ALU cycles. It connects directly to the datapath's `Opcode`/`z` outputs and control inputs.

## Interface
- `DEPTH`, 4: number of loop-counter stack entries. Power of two, minimum 2.
- `CW`, 4: loop-counter width in bits. Must hold values up to 8.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous reset, active-high.
- `Opcode` input 6: current instruction bits [15:10], laid out as {class[2:0], f[2:0]}.
- `z` input 1: registered zero flag from the datapath flip-flop.
- `s_inc` output 1: 1 = next PC is PC+1; 0 = next PC is the jump address (instruction [9:0]).
- `s_inm` output 1: 1 = write the immediate (instruction [11:4]) to the register bank; 0 = write the ALU result.
- `we3` output 1: register-bank write enable.
- `wez` output 1: zero-flag write enable.
- `Op` output 3: ALU operation select.
- `depth` output 3: number of valid loop-stack entries, 0..DEPTH.
- `err` output 1: sticky error flag, set on loop-stack overflow or underflow.

## Operation
- Defaults for every instruction: `s_inc`=1, `s_inm`=0, `we3`=0, `wez`=0, `Op`=f.
- Control outputs are combinational from `Opcode`, `z` and the stack state. Stack state and `err` are registered.
- Decode by class:
  - 000 ALU: `we3`=1, `wez`=1, `Op`=f.
  - 001 LI: `s_inm`=1, `we3`=1.
  - 010 J: `s_inc`=0.
  - 011 JZ: `s_inc`=~z.
  - 100 JNZ: `s_inc`=z.
  - 101 NOP: defaults only.
  - 110 SETLC: push count f+1 (range 1..8); `depth`++.
  - 111 LOOP, with top of stack = c:
    - c>1: `s_inc`=0, top <= c-1.
    - c==1: `s_inc`=1, pop, `depth`--.
- Effect of LOOP: the body between SETLC and LOOP (LOOP jumps to the body start) executes exactly f+1 times.
- Nesting: an inner SETLC pushes on top of the stack, and the outer count is preserved beneath it.
- Overflow: SETLC with `depth`==DEPTH is dropped, the stack is unchanged, and `err` is set.
- Underflow: LOOP with `depth`==0 falls through (`s_inc`=1), the stack is unchanged, and `err` is set.
- `err` clears only on `reset`.
- JZ/JNZ use `z` as presented, i.e. the flag latched by the last ALU instruction.

## Timing
- While `reset`=1, outputs are forced to: `s_inc`=1, `s_inm`=0, `we3`=0, `wez`=0, `Op`=0, `depth`=0, `err`=0.
- `reset` clears the stack and `err` immediately (asynchronous), including in the middle of a loop. The first decode after reset release is the instruction at PC 0.
- Zero latency: control for the instruction in `Opcode` is valid in the same cycle. Every instruction takes one cycle.
- Stack push, pop, decrement and the `err` update take effect on the rising edge that ends the SETLC/LOOP cycle. `depth` reflects the update in the next cycle.
- The stack pointer never wraps: `depth` saturates at 0 and DEPTH per the overflow/underflow rules.
- The count decrement uses CW bits and never reaches 0 in a valid entry.

## Test plan
- ALU decode: `Opcode`=000_101 → `we3`=1, `wez`=1, `Op`=101, `s_inc`=1, `s_inm`=0.
- Conditional jump: JZ with `z`=1 → `s_inc`=0. With `z`=0 → `s_inc`=1. JNZ gives the inverse in both cases.
- Counted loop: SETLC f=2, a 2-instruction body, then LOOP. The LOOP cycles show `s_inc`=0,0,1. The body executes 3 times and `depth` goes 0→1→0.
- Nesting: outer SETLC f=1 around inner SETLC f=2. The inner body runs 6 times, the outer body 2 times, and `depth` peaks at 2, ending with `depth`=0 and `err`=0.
- Boundary conditions:
  - 5 consecutive SETLC → `depth`=4, `err`=1.
  - Then 1 LOOP with top=1 → pop, `depth`=3.
  - LOOP on an empty stack → `s_inc`=1, `err`=1.
- Reset mid-loop: assert `reset` asynchronously while `depth`=2 → `depth`=0, `err`=0 and outputs at reset defaults before the next clock edge.
